// File: rtl/br_dump_pkg.sv
// Shared datapath constants and FSM encoding for the register-dump block
// and the register file it reads from.
package br_dump_pkg;

  localparam int NREGS = 32;
  localparam int IDXW  = 5;
  localparam int DATAW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/br_dump.sv
// Streams a contiguous range of register-file entries out over a
// valid/ready port, one word per two cycles when the consumer keeps up.
module br_dump
  import br_dump_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDXW-1:0]  first,
  input  logic [IDXW-1:0]  last,
  output logic [IDXW-1:0]  a,
  input  logic [DATAW-1:0] rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  dump_state_t     state_q, state_d;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort always beats whatever else the current state would do, including
  // a simultaneous start in IDLE and a pending transfer in SEND.
  always_comb begin
    state_d   = state_q;
    a         = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          state_d = (first <= last) ? READ : DONE;
        end
      end
      READ: begin
        a       = idx_q;
        state_d = abort ? DONE : SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (abort) begin
          state_d = DONE;
        end else if (out_ready) begin
          state_d = out_last ? DONE : READ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // idx only advances on a non-final transfer, so it stops at last and can
  // never wrap even for the full 0..31 range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      last_q   <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            idx_q  <= first;
            last_q <= last;
          end
        end
        READ: begin
          if (!abort) begin
            out_data <= rd;
            out_idx  <= idx_q;
            out_last <= (idx_q == last_q);
          end
        end
        SEND: begin
          if (!abort && out_ready && !out_last) begin
            idx_q <= idx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_br_dump.sv
// Directed bench for br_dump with a behavioural register file behind a
// busy-controlled read-address mux.
module tb_br_dump;
  import br_dump_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [IDXW-1:0]  first;
  logic [IDXW-1:0]  last;
  logic [IDXW-1:0]  a;
  logic [DATAW-1:0] rd;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [DATAW-1:0] mem [NREGS];
  logic [IDXW-1:0]  host_addr;
  logic [IDXW-1:0]  rf_a1;
  logic             we;
  logic [IDXW-1:0]  wa;
  logic [DATAW-1:0] wd;

  int checks;
  int errors;
  int cycles;

  br_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first     (first),
    .last      (last),
    .a         (a),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read on a1, write lands at the clock edge.
  assign rf_a1 = busy ? a : host_addr;
  assign rd    = mem[rf_a1];

  always @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [IDXW-1:0] f, input logic [IDXW-1:0] l);
    first = f;
    last  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, " a"}, 32'(a), 32'd0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " out_data"}, out_data, 32'd0);
    checkOutput({tag, " out_idx"}, 32'(out_idx), 32'd0);
    checkOutput({tag, " out_last"}, 32'(out_last), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    first     = '0;
    last      = '0;
    out_ready = 1'b0;
    host_addr = '0;
    we        = 1'b0;
    wa        = '0;
    wd        = '0;

    #12;
    checkZeroOutputs("reset");
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < NREGS; i++) begin
      we = 1'b1;
      wa = 5'(i);
      wd = 32'(i * 32'h11);
      tick();
    end
    we = 1'b0;

    // Full 0..31 dump at full rate.
    out_ready = 1'b1;
    applyStimulus(5'd0, 5'd31);
    cycles = 0;
    for (int i = 0; i < NREGS; i++) begin
      checkOutput("full a", 32'(a), 32'(i));
      checkOutput("full read valid", 32'(out_valid), 32'd0);
      tick();
      cycles++;
      checkOutput("full valid", 32'(out_valid), 32'd1);
      checkOutput("full data", out_data, 32'(i * 32'h11));
      checkOutput("full idx", 32'(out_idx), 32'(i));
      checkOutput("full last", 32'(out_last), (i == 31) ? 32'd1 : 32'd0);
      tick();
      cycles++;
    end
    checkOutput("full cycles", 32'(cycles), 32'd64);
    checkOutput("full done", 32'(done), 32'd1);
    checkOutput("full done a", 32'(a), 32'd0);
    checkOutput("full done valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("full idle done", 32'(done), 32'd0);
    checkOutput("full idle busy", 32'(busy), 32'd0);

    // Backpressure on word 4, with a stray start while busy.
    applyStimulus(5'd3, 5'd5);
    tick();
    checkOutput("bp w3 data", out_data, 32'h33);
    checkOutput("bp w3 idx", 32'(out_idx), 32'd3);
    tick();
    out_ready = 1'b0;
    start     = 1'b1;
    first     = 5'd0;
    last      = 5'd31;
    tick();
    for (int s = 0; s < 3; s++) begin
      checkOutput("bp stall valid", 32'(out_valid), 32'd1);
      checkOutput("bp stall data", out_data, 32'h44);
      checkOutput("bp stall idx", 32'(out_idx), 32'd4);
      if (s < 2) tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("bp w5 data", out_data, 32'h55);
    checkOutput("bp w5 idx", 32'(out_idx), 32'd5);
    checkOutput("bp w5 last", 32'(out_last), 32'd1);
    tick();
    checkOutput("bp done", 32'(done), 32'd1);
    tick();
    checkOutput("bp idle", 32'(busy), 32'd0);

    // Empty range.
    applyStimulus(5'd7, 5'd2);
    checkOutput("empty busy", 32'(busy), 32'd1);
    checkOutput("empty done", 32'(done), 32'd1);
    checkOutput("empty valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("empty busy after", 32'(busy), 32'd0);
    checkOutput("empty done after", 32'(done), 32'd0);

    // Write collision on register 4.
    we = 1'b1; wa = 5'd4; wd = 32'hAAAA_AAAA;
    tick();
    we = 1'b0;
    applyStimulus(5'd4, 5'd4);
    we = 1'b1; wa = 5'd4; wd = 32'h5555_5555;
    tick();
    we = 1'b0;
    checkOutput("collision old", out_data, 32'hAAAA_AAAA);
    tick();
    tick();
    applyStimulus(5'd4, 5'd4);
    tick();
    checkOutput("collision new", out_data, 32'h5555_5555);
    tick();
    tick();

    // Abort while word 10 is offered.
    applyStimulus(5'd10, 5'd12);
    tick();
    checkOutput("abort w10 valid", 32'(out_valid), 32'd1);
    checkOutput("abort w10 idx", 32'(out_idx), 32'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort valid drop", 32'(out_valid), 32'd0);
    checkOutput("abort done", 32'(done), 32'd1);
    tick();
    checkOutput("abort idle busy", 32'(busy), 32'd0);
    checkOutput("abort single done", 32'(done), 32'd0);

    // Start and abort together in IDLE.
    abort = 1'b1;
    applyStimulus(5'd0, 5'd3);
    abort = 1'b0;
    checkOutput("start+abort busy", 32'(busy), 32'd0);
    checkOutput("start+abort done", 32'(done), 32'd0);

    // Reset in the middle of word 20.
    applyStimulus(5'd0, 5'd31);
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
    end
    tick();
    checkOutput("pre-reset idx", 32'(out_idx), 32'd20);
    rst_n = 1'b0;
    #1;
    checkZeroOutputs("mid reset");
    tick();
    checkOutput("reset no done", 32'(done), 32'd0);
    rst_n = 1'b1;
    applyStimulus(5'd0, 5'd0);
    checkOutput("post-reset busy", 32'(busy), 32'd1);
    tick();
    checkOutput("post-reset valid", 32'(out_valid), 32'd1);
    checkOutput("post-reset data", out_data, 32'd0);
    checkOutput("post-reset last", 32'(out_last), 32'd1);
    tick();
    checkOutput("post-reset done", 32'(done), 32'd1);
    tick();
    checkOutput("post-reset idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_dump.md
BR_DUMP -- requirements
Module: br_dump

Interface
REQ-001 The block SHALL have no parameters; register count is fixed at 32 and data width at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a dump; sampled only in IDLE.
REQ-005 abort  input  1  cancel any dump in progress.
REQ-006 first  input  5  first register index, sampled when start is accepted.
REQ-007 last  input  5  last register index, sampled when start is accepted.
REQ-008 a  output  5  read address driven to the register file read port.
REQ-009 rd  input  32  combinational read data returned by the register file for address a.
REQ-010 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 out_data  output  32  captured register value.
REQ-013 out_idx  output  5  index of the register held in out_data.
REQ-014 out_last  output  1  word is the final one of the dump.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a dump completes or is aborted.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, READ, SEND, DONE.
- IDLE: start=1 and abort=0 -> latch first/last, set idx=first. Next state is READ if first<=last, else DONE (empty dump, no words emitted).
- READ: a=idx; on the edge, capture rd into out_data and idx into out_idx; set out_last=(idx==last_latched). Next state is SEND.
- SEND: out_valid=1. Outputs SHALL hold stable until out_valid&out_ready at an edge. On transfer: next state is DONE if out_last, else idx+1 and READ.
- DONE: done=1 for exactly one cycle; next state is IDLE.
REQ-018 Throughput SHALL be one word per two cycles when out_ready is held high; start-to-first-out_valid latency SHALL be 2 cycles.
REQ-019 out_data SHALL be a snapshot of rd at the READ edge. A register-file write to the same address in that cycle SHALL yield the pre-write value.
REQ-020 In IDLE and DONE, a SHALL be 0.
REQ-021 idx SHALL never wrap. first=0, last=31 SHALL emit 32 words and terminate at index 31.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 abort in READ or SEND SHALL force DONE on the next edge and drop out_valid. No transfer SHALL be counted in that cycle, even if out_ready=1.
REQ-024 Simultaneous start and abort in IDLE: abort wins and the block SHALL stay in IDLE with no done pulse.
REQ-025 out_ready SHALL be ignored outside SEND.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE with a=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, and latched first/last=0.
REQ-027 Reset mid-dump SHALL abandon the dump without a done pulse. After release, the block SHALL accept start on the first clock edge.

Structure
REQ-028 FSM state encodings and the register-count constant (32) SHALL live in the shared datapath package; the register file SHALL also use that constant.
REQ-029 The block SHALL be a single module with no sub-modules. It SHALL connect to the register file's first read port (a1/rd1) via a top-level mux that selects the dump address while busy=1.

Verification
REQ-030 Full dump: registers preloaded with mem[i]=i*0x11; start with first=0, last=31; out_ready=1 -> 32 words, out_data=i*0x11, out_idx=i, out_last only at i=31, done one cycle after the final transfer, 64 cycles total.
REQ-031 Backpressure: dump first=3, last=5 with out_ready toggling 1,0,0,1 -> three words 3,4,5; out_data/out_idx stable while stalled.
REQ-032 Empty range: first=7, last=2 -> no out_valid, done pulse 1 cycle after start, busy high exactly 1 cycle.
REQ-033 Write collision: register 4 holds 0xAAAA_AAAA; write 0x5555_5555 to register 4 in the READ cycle for idx=4 -> out_data=0xAAAA_AAAA; the next dump returns 0x5555_5555.
REQ-034 Abort: abort in SEND during word idx=10 with out_ready=1 -> that word is not transferred, out_valid falls next cycle, done pulses once, then IDLE.
REQ-035 Reset mid-dump: rst_n low for 1 cycle at idx=20 -> all outputs 0, no done; a new start with first=0, last=0 yields a single word with out_last=1.
